// File: rtl/training_sequencer_pkg.sv
// Shared types and default sizing for the training sequencer.
package training_sequencer_pkg;

  // Run-control FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Default geometry of a training run.
  localparam int BA_DEF     = 8;   // step width
  localparam int BB_DEF     = 4;   // stage width
  localparam int BC_DEF     = 16;  // epoch width
  localparam int N_DEF      = 40;  // lane count
  localparam int NSTAGE_DEF = 12;  // stages per epoch
  localparam int WR_LAG_DEF = 40;  // read-to-write lag in active cycles

endpackage

// File: rtl/training_sequencer_pos.sv
// Step/stage/epoch position counter shared by the read and write sides.
module pos_counter
  import training_sequencer_pkg::*;
#(
  parameter int BA     = BA_DEF,
  parameter int BB     = BB_DEF,
  parameter int BC     = BC_DEF,
  parameter int NSTAGE = NSTAGE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [BA-1:0] step_last,
  output logic [BA-1:0] step,
  output logic [BB-1:0] stage,
  output logic [BC-1:0] epoch,
  output logic          lstep,
  output logic          lstage
);

  localparam logic [BB-1:0] STAGE_LAST = BB'(NSTAGE - 1);

  assign lstep  = (step == step_last);
  assign lstage = (stage == STAGE_LAST);

  // Nested step -> stage -> epoch count; clear wins over enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step  <= '0;
      stage <= '0;
      epoch <= '0;
    end else if (clr) begin
      step  <= '0;
      stage <= '0;
      epoch <= '0;
    end else if (en) begin
      if (lstep) begin
        step <= '0;
        if (lstage) begin
          stage <= '0;
          epoch <= epoch + BC'(1);
        end else begin
          stage <= stage + BB'(1);
        end
      end else begin
        step <= step + BA'(1);
      end
    end
  end

endmodule

// File: rtl/training_sequencer.sv
// Training sequencer: walks a read position through step/stage/epoch, trails
// it with a write position delayed by WR_LAG active cycles, and reports done
// once the write side has reached the final position.
module training_sequencer
  import training_sequencer_pkg::*;
#(
  parameter int BA         = BA_DEF,
  parameter int BB         = BB_DEF,
  parameter int BC         = BC_DEF,
  parameter int N          = N_DEF,
  parameter int BM         = $clog2(N),
  parameter int NSTAGE     = NSTAGE_DEF,
  parameter int WR_LAG     = WR_LAG_DEF,
  parameter int REQ_STAGE  = 10,
  parameter int STAT_STAGE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  input  logic [BA-1:0] cfg_step_last,
  input  logic [BC-1:0] cfg_epoch_last,
  output logic [BA-1:0] rd_step,
  output logic [BB-1:0] rd_stage,
  output logic [BC-1:0] rd_epoch,
  output logic          rd_lstep,
  output logic [BA-1:0] wr_step,
  output logic [BB-1:0] wr_stage,
  output logic          wr_lstep,
  output logic          wr_valid,
  output logic [BM-1:0] dest_addr,
  output logic [BM-1:0] source_addr,
  output logic          request_in,
  output logic          status,
  output logic          busy,
  output logic          done
);

  localparam logic [BB-1:0] REQ_STAGE_C  = BB'(REQ_STAGE);
  localparam logic [BB-1:0] STAT_STAGE_C = BB'(STAT_STAGE);
  localparam logic [BM-1:0] ADDR_LAST    = BM'(N - 1);
  localparam int            LW           = (WR_LAG > 1) ? $clog2(WR_LAG) : 1;
  localparam logic [LW-1:0] LAG_LAST     = LW'(WR_LAG - 1);

  state_t        state;
  state_t        state_nxt;
  logic [BA-1:0] step_last_q;
  logic [BC-1:0] epoch_last_q;
  logic [LW-1:0] lag_cnt;
  logic          go;
  logic          active;
  logic          rd_en;
  logic          wr_en;
  logic          rd_lstage;
  logic          wr_lstage;
  logic          wr_lstep_raw;
  logic [BC-1:0] wr_epoch;
  logic          rd_final;
  logic          wr_final;

  // A run is launched only from IDLE; start is ignored everywhere else.
  assign go     = (state == IDLE) && start;
  // Counters move only in RUN/DRAIN and only when not stalled.
  assign active = ((state == RUN) || (state == DRAIN)) && !stall;

  assign rd_final = rd_lstep && rd_lstage && (rd_epoch == epoch_last_q);
  assign wr_final = wr_valid && wr_lstep_raw && wr_lstage && (wr_epoch == epoch_last_q);

  // Each side stops once it sits on the final position.
  assign rd_en = active && (state == RUN) && !rd_final;
  assign wr_en = active && wr_valid && !wr_final;

  pos_counter #(
    .BA     (BA),
    .BB     (BB),
    .BC     (BC),
    .NSTAGE (NSTAGE)
  ) u_rd_pos (
    .clk       (clk),
    .rst       (rst),
    .clr       (go),
    .en        (rd_en),
    .step_last (step_last_q),
    .step      (rd_step),
    .stage     (rd_stage),
    .epoch     (rd_epoch),
    .lstep     (rd_lstep),
    .lstage    (rd_lstage)
  );

  pos_counter #(
    .BA     (BA),
    .BB     (BB),
    .BC     (BC),
    .NSTAGE (NSTAGE)
  ) u_wr_pos (
    .clk       (clk),
    .rst       (rst),
    .clr       (go),
    .en        (wr_en),
    .step_last (step_last_q),
    .step      (wr_step),
    .stage     (wr_stage),
    .epoch     (wr_epoch),
    .lstep     (wr_lstep_raw),
    .lstage    (wr_lstage)
  );

  assign wr_lstep    = wr_valid && wr_lstep_raw;
  assign source_addr = rd_lstage ? ADDR_LAST : dest_addr;
  assign request_in  = busy && (rd_stage >= REQ_STAGE_C);
  assign status      = wr_valid && (wr_stage >= STAT_STAGE_C);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode plus the busy/done status decoded from state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (active && rd_final) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (active && wr_final) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration is captured once per run so mid-run cfg changes are inert.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_last_q  <= '0;
      epoch_last_q <= '0;
    end else if (go) begin
      step_last_q  <= cfg_step_last;
      epoch_last_q <= cfg_epoch_last;
    end
  end

  // Lag counter: opens the write side after WR_LAG active cycles and closes
  // it again when the final write position is consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lag_cnt  <= '0;
      wr_valid <= 1'b0;
    end else if (go) begin
      lag_cnt  <= '0;
      wr_valid <= 1'b0;
    end else if ((state == DRAIN) && active && wr_final) begin
      wr_valid <= 1'b0;
    end else if (active && !wr_valid) begin
      if (lag_cnt == LAG_LAST) wr_valid <= 1'b1;
      else                     lag_cnt  <= lag_cnt + LW'(1);
    end
  end

  // Lane counter: wraps at N-1 and restarts whenever the read stage moves on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dest_addr <= '0;
    end else if (go) begin
      dest_addr <= '0;
    end else if (active && (state == RUN)) begin
      if (rd_lstep || (dest_addr == ADDR_LAST)) dest_addr <= '0;
      else                                      dest_addr <= dest_addr + BM'(1);
    end
  end

endmodule

// File: tb/tb_training_sequencer.sv
// Scoreboard bench for training_sequencer (N=4, NSTAGE=3, WR_LAG=2).
module tb_training_sequencer;

  localparam int BA         = 8;
  localparam int BB         = 4;
  localparam int BC         = 16;
  localparam int N          = 4;
  localparam int BM         = 2;
  localparam int NSTAGE     = 3;
  localparam int WR_LAG     = 2;
  localparam int REQ_STAGE  = 10;
  localparam int STAT_STAGE = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [BA-1:0] cfg_step_last = '0;
  logic [BC-1:0] cfg_epoch_last = '0;
  logic [BA-1:0] rd_step;
  logic [BB-1:0] rd_stage;
  logic [BC-1:0] rd_epoch;
  logic          rd_lstep;
  logic [BA-1:0] wr_step;
  logic [BB-1:0] wr_stage;
  logic          wr_lstep;
  logic          wr_valid;
  logic [BM-1:0] dest_addr;
  logic [BM-1:0] source_addr;
  logic          request_in;
  logic          status;
  logic          busy;
  logic          done;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [BA-1:0] rd_step;
    logic [BB-1:0] rd_stage;
    logic [BC-1:0] rd_epoch;
    logic          rd_lstep;
    logic          wr_valid;
    logic [BA-1:0] wr_step;
    logic [BB-1:0] wr_stage;
    logic          wr_lstep;
    logic [BM-1:0] dest;
    logic [BM-1:0] src;
    logic          req;
    logic          status;
  } obs_t;

  obs_t exp_q[$];
  bit   stall_q[$];
  int   total = 0;
  int   bad = 0;

  training_sequencer #(
    .BA(BA), .BB(BB), .BC(BC), .N(N), .BM(BM), .NSTAGE(NSTAGE),
    .WR_LAG(WR_LAG), .REQ_STAGE(REQ_STAGE), .STAT_STAGE(STAT_STAGE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stall          (stall),
    .cfg_step_last  (cfg_step_last),
    .cfg_epoch_last (cfg_epoch_last),
    .rd_step        (rd_step),
    .rd_stage       (rd_stage),
    .rd_epoch       (rd_epoch),
    .rd_lstep       (rd_lstep),
    .wr_step        (wr_step),
    .wr_stage       (wr_stage),
    .wr_lstep       (wr_lstep),
    .wr_valid       (wr_valid),
    .dest_addr      (dest_addr),
    .source_addr    (source_addr),
    .request_in     (request_in),
    .status         (status),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy;         o.done = done;
    o.rd_step = rd_step;   o.rd_stage = rd_stage; o.rd_epoch = rd_epoch;
    o.rd_lstep = rd_lstep; o.wr_valid = wr_valid;
    o.wr_step = wr_step;   o.wr_stage = wr_stage; o.wr_lstep = wr_lstep;
    o.dest = dest_addr;    o.src = source_addr;
    o.req = request_in;    o.status = status;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("b%0d d%0d rd=%0d/%0d/%0d l%0d wv%0d wr=%0d/%0d l%0d da=%0d sa=%0d rq%0d st%0d",
                     o.busy, o.done, o.rd_step, o.rd_stage, o.rd_epoch, o.rd_lstep, o.wr_valid,
                     o.wr_step, o.wr_stage, o.wr_lstep, o.dest, o.src, o.req, o.status);
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.rd_lstep = 1'b1;
    return o;
  endfunction

  // Reference model: position i of a run is (i%(s+1), (i/(s+1))%NSTAGE, i/((s+1)*NSTAGE)).
  // Cycle t (1 = first cycle after the start edge) sees a = active cycles so far.
  function automatic void model_run(input int s, input int e, input int st_at, input int st_len);
    int   p, a, t, ri, wi;
    bit   stl;
    obs_t o;
    p = (e + 1) * NSTAGE * (s + 1);
    a = 0;
    t = 1;
    while (a < p + WR_LAG) begin
      ri = (a < p) ? a : p - 1;
      o = '0;
      o.busy     = 1'b1;
      o.rd_step  = BA'(ri % (s + 1));
      o.rd_stage = BB'((ri / (s + 1)) % NSTAGE);
      o.rd_epoch = BC'(ri / ((s + 1) * NSTAGE));
      o.rd_lstep = ((ri % (s + 1)) == s);
      o.wr_valid = (a >= WR_LAG);
      if (o.wr_valid) begin
        wi = a - WR_LAG;
        o.wr_step  = BA'(wi % (s + 1));
        o.wr_stage = BB'((wi / (s + 1)) % NSTAGE);
        o.wr_lstep = ((wi % (s + 1)) == s);
        o.status   = (((wi / (s + 1)) % NSTAGE) >= STAT_STAGE);
      end
      o.dest = (a < p) ? BM'((ri % (s + 1)) % N) : '0;
      o.src  = (o.rd_stage == BB'(NSTAGE - 1)) ? BM'(N - 1) : o.dest;
      o.req  = (((ri / (s + 1)) % NSTAGE) >= REQ_STAGE);
      exp_q.push_back(o);
      stl = (t >= st_at) && (t < st_at + st_len);
      stall_q.push_back(stl);
      if (!stl) a++;
      t++;
    end
    o = '0;
    o.done     = 1'b1;
    o.rd_step  = BA'(s);
    o.rd_stage = BB'(NSTAGE - 1);
    o.rd_epoch = BC'(e);
    o.rd_lstep = 1'b1;
    o.wr_step  = BA'(s);
    o.wr_stage = BB'(NSTAGE - 1);
    o.src      = BM'(N - 1);
    exp_q.push_back(o);
    stall_q.push_back(1'b0);
    o.done = 1'b0;
    exp_q.push_back(o);
    stall_q.push_back(1'b0);
  endfunction

  task automatic test_reset();
    obs_t got;
    rst = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      got = sample();
      total++;
      if (got !== reset_obs()) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got %s want %s", i, fmt(got), fmt(reset_obs()));
      end
    end
    start = 1'b0;
    #2 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      got = sample();
      total++;
      if (got !== reset_obs()) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got %s want %s", i, fmt(got), fmt(reset_obs()));
      end
    end
  endtask

  task automatic test_basic();
    obs_t want, got;
    int   cyc, busy_n, first_wv, done_cyc, done_n;
    cyc = 0; busy_n = 0; first_wv = 0; done_cyc = 0; done_n = 0;
    model_run(1, 0, 0, 0);
    cfg_step_last = 8'd1; cfg_epoch_last = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (exp_q.size() > 0) begin
      cyc++;
      want = exp_q.pop_front();
      stall = stall_q.pop_front();
      got = sample();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL basic cyc=%0d got %s want %s", cyc, fmt(got), fmt(want));
      end
      if (got.busy) busy_n++;
      if (got.wr_valid && first_wv == 0) first_wv = cyc;
      if (got.done) begin done_n++; done_cyc = cyc; end
      @(posedge clk); #1;
    end
    stall = 1'b0;
    total++;
    if (busy_n !== 8) begin bad++; $display("FAIL basic_busy_len got %0d want 8", busy_n); end
    total++;
    if (first_wv !== 3) begin bad++; $display("FAIL basic_wv_first got %0d want 3", first_wv); end
    total++;
    if (done_cyc !== 9) begin bad++; $display("FAIL basic_done_cyc got %0d want 9", done_cyc); end
    total++;
    if (done_n !== 1) begin bad++; $display("FAIL basic_done_cnt got %0d want 1", done_n); end
  endtask

  task automatic test_stall();
    obs_t want, got;
    int   cyc, done_cyc;
    cyc = 0; done_cyc = 0;
    model_run(1, 0, 4, 3);
    cfg_step_last = 8'd1; cfg_epoch_last = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (exp_q.size() > 0) begin
      cyc++;
      want = exp_q.pop_front();
      stall = stall_q.pop_front();
      got = sample();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL stall cyc=%0d got %s want %s", cyc, fmt(got), fmt(want));
      end
      if (got.done) done_cyc = cyc;
      @(posedge clk); #1;
    end
    stall = 1'b0;
    total++;
    if (done_cyc !== 12) begin bad++; $display("FAIL stall_done_cyc got %0d want 12", done_cyc); end
  endtask

  task automatic test_dest();
    obs_t want, got;
    int   cyc;
    int   dseq[7];
    dseq = '{0, 1, 2, 3, 0, 1, 0};
    cyc = 0;
    model_run(5, 0, 0, 0);
    cfg_step_last = 8'd5; cfg_epoch_last = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (exp_q.size() > 0) begin
      cyc++;
      want = exp_q.pop_front();
      stall = stall_q.pop_front();
      got = sample();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL dest cyc=%0d got %s want %s", cyc, fmt(got), fmt(want));
      end
      if (cyc <= 7) begin
        total++;
        if (got.dest !== BM'(dseq[cyc-1])) begin
          bad++;
          $display("FAIL dest_seq cyc=%0d got %0d want %0d", cyc, got.dest, dseq[cyc-1]);
        end
      end
      if (got.busy && got.rd_stage == BB'(2)) begin
        total++;
        if (got.src !== 2'd3) begin
          bad++;
          $display("FAIL src_last_stage cyc=%0d got %0d want 3", cyc, got.src);
        end
      end
      @(posedge clk); #1;
    end
    stall = 1'b0;
  endtask

  task automatic test_epochs();
    obs_t want, got;
    int   cyc, req_n, last_epoch;
    cyc = 0; req_n = 0; last_epoch = -1;
    model_run(0, 2, 0, 0);
    cfg_step_last = 8'd0; cfg_epoch_last = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (exp_q.size() > 0) begin
      cyc++;
      want = exp_q.pop_front();
      stall = stall_q.pop_front();
      got = sample();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL epochs cyc=%0d got %s want %s", cyc, fmt(got), fmt(want));
      end
      if (cyc <= 9) begin
        total++;
        if (got.rd_stage !== BB'((cyc - 1) % NSTAGE)) begin
          bad++;
          $display("FAIL epochs_stage cyc=%0d got %0d want %0d", cyc, got.rd_stage, (cyc - 1) % NSTAGE);
        end
      end
      if (got.req) req_n++;
      if (got.done) last_epoch = int'(got.rd_epoch);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    total++;
    if (req_n !== 0) begin bad++; $display("FAIL epochs_request got %0d want 0", req_n); end
    total++;
    if (last_epoch !== 2) begin bad++; $display("FAIL epochs_final got %0d want 2", last_epoch); end
  endtask

  // start held while busy, cfg changed mid-run, stall in IDLE and DONE.
  task automatic test_start_busy();
    obs_t want, got;
    int   cyc;
    cyc = 0;
    model_run(1, 0, 0, 0);
    cfg_step_last = 8'd1; cfg_epoch_last = 16'd0; start = 1'b1; stall = 1'b1;
    @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      cyc++;
      want = exp_q.pop_front();
      stall = stall_q.pop_front() | want.done;
      start = want.busy;
      if (cyc == 2) begin cfg_step_last = 8'd3; cfg_epoch_last = 16'd1; end
      got = sample();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL start_busy cyc=%0d got %s want %s", cyc, fmt(got), fmt(want));
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_mid_reset();
    obs_t want, got;
    int   cyc;
    cyc = 0;
    model_run(1, 0, 0, 0);
    cfg_step_last = 8'd1; cfg_epoch_last = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 7) begin
      cyc++;
      want = exp_q.pop_front();
      stall = stall_q.pop_front();
      got = sample();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL pre_reset cyc=%0d got %s want %s", cyc, fmt(got), fmt(want));
      end
      if (cyc < 7) begin @(posedge clk); #1; end
    end
    exp_q.delete();
    stall_q.delete();
    #2 rst = 1'b0;
    #1;
    got = sample();
    total++;
    if (got !== reset_obs()) begin
      bad++;
      $display("FAIL reset_async got %s want %s", fmt(got), fmt(reset_obs()));
    end
    @(posedge clk); #1;
    got = sample();
    total++;
    if (got !== reset_obs()) begin
      bad++;
      $display("FAIL reset_next got %s want %s", fmt(got), fmt(reset_obs()));
    end
    #3 rst = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    model_run(1, 0, 0, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (exp_q.size() > 0) begin
      cyc++;
      want = exp_q.pop_front();
      stall = stall_q.pop_front();
      got = sample();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL post_reset cyc=%0d got %s want %s", cyc, fmt(got), fmt(want));
      end
      @(posedge clk); #1;
    end
    stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_dest();
    test_epochs();
    test_start_busy();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/training_sequencer.md
TRAINING_SEQUENCER -- requirements
Module: training_sequencer

Interface
REQ-001 Parameters SHALL be:
- BA, 8, step width.
- BB, 4, stage width.
- BC, 16, epoch width.
- N, 40, lane count.
- BM, clog2(N), lane address width.
- NSTAGE, 12, stages per epoch.
- WR_LAG, 40, read-to-write lag in active cycles (>=1).
- REQ_STAGE, 10, first stage asserting request_in.
- STAT_STAGE, 4, first write stage asserting status.
REQ-002 Ports SHALL be:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin run (sampled in IDLE only).
- stall  in  1  freeze all counters.
- cfg_step_last  in  BA  last step index per stage.
- cfg_epoch_last  in  BC  last epoch index.
- rd_step  out  BA  read step.
- rd_stage  out  BB  read stage.
- rd_epoch  out  BC  read epoch.
- rd_lstep  out  1  read at last step.
- wr_step  out  BA  write step.
- wr_stage  out  BB  write stage.
- wr_lstep  out  1  write at last step.
- wr_valid  out  1  write position meaningful.
- dest_addr  out  BM  lane counter.
- source_addr  out  BM  lane source.
- request_in  out  1  input request.
- status  out  1  write-side status.
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 FSM states SHALL be IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-004 IDLE with start=1 SHALL latch cfg_step_last and cfg_epoch_last, clear all counters, and enter RUN next cycle; cfg inputs SHALL be ignored outside IDLE.
REQ-005 An active cycle SHALL be a cycle in RUN or DRAIN with stall=0; counters SHALL change only on active cycles.
REQ-006 Read position SHALL advance per active RUN cycle: step 0..cfg_step_last, then step->0 with stage+1; stage NSTAGE-1 wraps to 0 with epoch+1.
REQ-007 rd_lstep SHALL equal (rd_step==cfg_step_last) combinationally.
REQ-008 At the active cycle with read position (cfg_step_last, NSTAGE-1, cfg_epoch_last), the FSM SHALL enter DRAIN; the read position SHALL then hold.
REQ-009 A lag counter SHALL count active cycles; wr_valid SHALL rise after exactly WR_LAG active cycles, when the write position starts at (0,0).
REQ-010 While wr_valid=1, the write position SHALL advance per active cycle by the rules of REQ-006, so the write position equals the read position of WR_LAG active cycles earlier.
REQ-011 wr_lstep SHALL equal wr_valid && (wr_step==cfg_step_last).
REQ-012 At the active DRAIN cycle where the write position is the final position of REQ-008, the FSM SHALL enter DONE; DONE SHALL assert done for one cycle, then return to IDLE.
REQ-013 busy SHALL be 1 in RUN and DRAIN, else 0.
REQ-014 dest_addr SHALL increment per active RUN cycle, wrap N-1 -> 0, and clear to 0 on any read stage change.
REQ-015 source_addr SHALL be N-1 while rd_stage==NSTAGE-1, else dest_addr.
REQ-016 request_in SHALL be busy && rd_stage>=REQ_STAGE; status SHALL be wr_valid && wr_stage>=STAT_STAGE.
REQ-017 cfg_step_last=0 SHALL advance the stage every active cycle; cfg_epoch_last=0 SHALL run one epoch.
REQ-018 start while busy SHALL be ignored; stall in IDLE or DONE SHALL have no effect.

Reset
REQ-019 rst=0 SHALL immediately clear all counters, wr_valid, busy and done, and force IDLE, including mid-run; no partial state SHALL survive.
REQ-020 Reset values SHALL be: all position and address outputs 0; rd_lstep 1 only if the latched cfg_step_last (reset 0) is 0, i.e. 1 after reset; wr_lstep, request_in, status, busy and done 0.

Structure
REQ-021 A shared package SHALL hold the FSM state enum and the default parameter constants (BA, BB, BC, N, NSTAGE, WR_LAG).
REQ-022 One sub-module, pos_counter (step/stage/epoch with enable, clear and last flags), SHALL be instantiated twice, once for read and once for write.

Verification (N=4, NSTAGE=3, WR_LAG=2)
REQ-023 start, cfg_step_last=1, cfg_epoch_last=0, no stall -> busy for 8 cycles; wr_valid from the 3rd RUN cycle; done pulses once, 9 cycles after the start edge.
REQ-024 Same run with stall=1 for 3 cycles mid-run -> all counters frozen during the stall; done pulse delayed by exactly 3 cycles.
REQ-025 cfg_step_last=5 -> dest_addr sequence 0,1,2,3,0,1, then 0 at the stage change; source_addr=3 throughout stage 2.
REQ-026 rst=0 asserted in DRAIN -> next cycle in IDLE, all outputs at reset values; a subsequent start produces a full run.
REQ-027 cfg_step_last=0, cfg_epoch_last=2 -> read stage sequence 0,1,2 repeated 3 times, rd_epoch ending at 2; request_in never asserts with REQ_STAGE=10.
